// File: rtl/cache_mem_arbiter_pkg.sv
// Message types shared by the caches, the memory port and the arbiter between them.
package cache_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the two cache-side val/rdy ports and the shared memory port.
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    logic         req0_val;
    logic         req0_rdy;
    mem_req_4B_t  req0_msg;
    logic         resp0_val;
    logic         resp0_rdy;
    mem_resp_4B_t resp0_msg;

    logic         req1_val;
    logic         req1_rdy;
    mem_req_4B_t  req1_msg;
    logic         resp1_val;
    logic         resp1_rdy;
    mem_resp_4B_t resp1_msg;

    logic         mem_req_val;
    logic         mem_req_rdy;
    mem_req_4B_t  mem_req_msg;
    logic         mem_resp_val;
    logic         mem_resp_rdy;
    mem_resp_4B_t mem_resp_msg;

    // Arbiter side.
    modport slave (
        input  req0_val, req0_msg, resp0_rdy,
        input  req1_val, req1_msg, resp1_rdy,
        input  mem_req_rdy, mem_resp_val, mem_resp_msg,
        output req0_rdy, resp0_val, resp0_msg,
        output req1_rdy, resp1_val, resp1_msg,
        output mem_req_val, mem_req_msg, mem_resp_rdy
    );

    // Caches plus memory side.
    modport master (
        output req0_val, req0_msg, resp0_rdy,
        output req1_val, req1_msg, resp1_rdy,
        output mem_req_rdy, mem_resp_val, mem_resp_msg,
        input  req0_rdy, resp0_val, resp0_msg,
        input  req1_rdy, resp1_val, resp1_msg,
        input  mem_req_val, mem_req_msg, mem_resp_rdy
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin burst arbiter sharing one memory port between icache (port 0) and dcache (port 1);
// an ID FIFO routes the in-order memory responses back to the issuing port.
module cache_mem_arbiter #(
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    cache_mem_arbiter_if.slave                 bus,
    output logic [1:0]                         grant,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int unsigned CntW = $clog2(BURST_LEN);
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OccW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e                     r_state, w_state_nxt;
    logic                       r_prio, w_prio_nxt;
    logic [CntW-1:0]            r_cnt, w_cnt_nxt;
    logic [MAX_OUTSTANDING-1:0] r_ids;
    logic [PtrW-1:0]            r_wptr, r_rptr;
    logic [OccW-1:0]            r_occ;

    logic   w_full, w_empty;
    logic   w_port, w_val_own, w_val_oth, w_xfer, w_pop, w_head;
    state_e w_other;

    assign w_full  = (r_occ == OccW'(MAX_OUTSTANDING));
    assign w_empty = (r_occ == '0);
    assign w_port  = (r_state == StGrant1);
    assign w_other = w_port ? StGrant0 : StGrant1;

    assign grant       = {r_state == StGrant1, r_state == StGrant0};
    assign outstanding = r_occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prio_nxt      = r_prio;
        w_cnt_nxt       = r_cnt;
        w_val_own       = w_port ? bus.req1_val : bus.req0_val;
        w_val_oth       = w_port ? bus.req0_val : bus.req1_val;
        bus.mem_req_msg = w_port ? bus.req1_msg : bus.req0_msg;
        bus.mem_req_val = 1'b0;
        bus.req0_rdy    = 1'b0;
        bus.req1_rdy    = 1'b0;
        w_xfer          = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (bus.req0_val && bus.req1_val) begin
                    w_state_nxt = r_prio ? StGrant1 : StGrant0;
                end else if (bus.req0_val) begin
                    w_state_nxt = StGrant0;
                end else if (bus.req1_val) begin
                    w_state_nxt = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                bus.mem_req_val = w_val_own & ~w_full;
                bus.req0_rdy    = ~w_port & bus.mem_req_rdy & ~w_full;
                bus.req1_rdy    =  w_port & bus.mem_req_rdy & ~w_full;
                w_xfer          = bus.mem_req_val & bus.mem_req_rdy;
                if (!w_val_own) begin
                    // Owner dropped its request: hand over without waiting out the burst.
                    w_prio_nxt  = ~w_port;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_val_oth ? w_other : StIdle;
                end else if (w_xfer) begin
                    if (r_cnt == CntW'(BURST_LEN - 1)) begin
                        w_prio_nxt  = ~w_port;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_val_oth ? w_other : r_state;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // ID FIFO: one bit per accepted request naming the issuing port.
    assign w_head           = r_ids[r_rptr];
    assign bus.resp0_val    = bus.mem_resp_val & ~w_empty & ~w_head;
    assign bus.resp1_val    = bus.mem_resp_val & ~w_empty &  w_head;
    assign bus.resp0_msg    = bus.mem_resp_msg;
    assign bus.resp1_msg    = bus.mem_resp_msg;
    assign bus.mem_resp_rdy = ~w_empty & (w_head ? bus.resp1_rdy : bus.resp0_rdy);
    assign w_pop            = bus.mem_resp_val & bus.mem_resp_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ids  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_xfer) begin
                r_ids[r_wptr] <= w_port;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_occ <= r_occ + OccW'(w_xfer) - OccW'(w_pop);
        end
    end

endmodule
